// File: rtl/sgd_x_updated_drain.sv
// sgd_x_updated_drain
//   Streams the trained model out of the x_updated BRAM bank. The block reads
//   word addresses 0..N-1 in order, absorbs the BRAM read latency with a
//   valid shift register, and buffers the returned words in a small prefetch
//   FIFO. That FIFO feeds a registered first-word-fall-through valid/ready
//   output. A credit check keeps in-flight reads plus buffered words within
//   FIFO_DEPTH, so the FIFO can never overflow.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, dimension    begin a drain; dimension is captured on start
//   x_updated_rd_addr   registered BRAM read address
//   x_updated_rd_data   BRAM read data, RD_LATENCY cycles after the address
//   x_out_*             output word stream (data/valid/ready/last)
//   busy, done          drain in progress / one-cycle completion pulse

`ifndef NUM_BITS_PER_BANK
`define NUM_BITS_PER_BANK 4
`endif
`ifndef DIS_X_BIT_DEPTH
`define DIS_X_BIT_DEPTH 10
`endif
`ifndef BIT_WIDTH_OF_BANK
`define BIT_WIDTH_OF_BANK 2
`endif
`ifndef ENGINE_NUM_WIDTH
`define ENGINE_NUM_WIDTH 1
`endif

module sgd_x_updated_drain #(
  parameter int LANES      = `NUM_BITS_PER_BANK,
  parameter int ADDR_BITS  = `DIS_X_BIT_DEPTH,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           dimension,
  output logic [ADDR_BITS-1:0]  x_updated_rd_addr,
  input  logic [LANES*32-1:0]   x_updated_rd_data,
  output logic [LANES*32-1:0]   x_out_data,
  output logic                  x_out_valid,
  input  logic                  x_out_ready,
  output logic                  x_out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = LANES * 32;
  localparam int S  = `BIT_WIDTH_OF_BANK + `ENGINE_NUM_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CALC  = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [31:0]           dim_q, dim_d;
  logic [31:0]           n_q, n_d;
  logic [31:0]           issued_q, issued_d;
  logic [31:0]           emitted_q, emitted_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic                  issue_q, issue_d;      // address is on the BRAM port this cycle
  logic [RD_LATENCY-1:0] sr_q, sr_d;            // read-latency tracking
  logic [W-1:0]          mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]          od_q, od_d;
  logic                  ov_q, ov_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [31:0]           n_calc_s;
  logic [7:0]            occ_s;
  logic                  credit_ok_s;
  logic                  pop_s, push_s, load_s, wr_en_s, last_s, idle_pipe_s;

  assign n_calc_s    = (dim_q >> S) + {31'd0, |dim_q[S-1:0]};
  assign pop_s       = ov_q & x_out_ready;
  assign push_s      = sr_q[RD_LATENCY-1];
  // The output register can take a new word when empty or being drained now.
  assign load_s      = ~ov_q | x_out_ready;
  assign last_s      = ov_q & (emitted_q == (n_q - 32'd1));
  assign idle_pipe_s = ~issue_q & (sr_q == {RD_LATENCY{1'b0}});

  // Occupancy after this edge's pop; counting the pop lets a full pipeline
  // keep issuing one read per cycle with ready held high.
  always_comb begin
    occ_s = {7'd0, issue_q};
    for (int i = 0; i < RD_LATENCY; i++) begin
      occ_s = occ_s + {7'd0, sr_q[i]};
    end
    occ_s = occ_s + 8'(cnt_q) + {7'd0, ov_q} - {7'd0, pop_s};
    credit_ok_s = (occ_s < 8'(FIFO_DEPTH));
  end

  // Drain sequencing: word count, read issue and completion.
  always_comb begin
    state_d   = state_q;
    dim_d     = dim_q;
    n_d       = n_q;
    issued_d  = issued_q;
    emitted_d = pop_s ? (emitted_q + 32'd1) : emitted_q;
    addr_d    = addr_q;
    issue_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        addr_d = {ADDR_BITS{1'b0}};
        if (start) begin
          dim_d     = dimension;
          n_d       = 32'd0;
          issued_d  = 32'd0;
          emitted_d = 32'd0;
          state_d   = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        n_d = n_calc_s;
        if (n_calc_s != 32'd0) begin
          // Pipeline is empty, so the first read needs no credit check.
          issue_d  = 1'b1;
          addr_d   = {ADDR_BITS{1'b0}};
          issued_d = 32'd1;
          state_d  = ST_READ;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_READ: begin
        if (issued_q == n_q) begin
          state_d = ST_FLUSH;
        end else if (credit_ok_s) begin
          issue_d  = 1'b1;
          addr_d   = issued_q[ADDR_BITS-1:0];
          issued_d = issued_q + 32'd1;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_FLUSH: begin
        if (pop_s && last_s && idle_pipe_s && (cnt_q == {CW{1'b0}})) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Read-latency shift register: a bit matures when its data is on the bus.
  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = issue_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Prefetch FIFO and registered output stage; a maturing word bypasses the
  // memory when the memory is empty and the output stage can load.
  always_comb begin
    od_d     = od_q;
    ov_d     = ov_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    wr_en_s  = push_s & ~(load_s & (cnt_q == {CW{1'b0}}));
    if (load_s) begin
      if (cnt_q != {CW{1'b0}}) begin
        od_d     = mem_q[rd_ptr_q];
        ov_d     = 1'b1;
        rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : (rd_ptr_q + PW'(1));
      end else if (push_s) begin
        od_d = x_updated_rd_data;
        ov_d = 1'b1;
      end else begin
        ov_d = 1'b0;
      end
    end else begin
      ov_d = ov_q;
    end
    if (wr_en_s) begin
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : (wr_ptr_q + PW'(1));
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    cnt_d = cnt_q + CW'(wr_en_s) - CW'(load_s && (cnt_q != {CW{1'b0}}));
  end

  // FIFO storage; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= x_updated_rd_data;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dim_q     <= 32'd0;
      n_q       <= 32'd0;
      issued_q  <= 32'd0;
      emitted_q <= 32'd0;
      addr_q    <= {ADDR_BITS{1'b0}};
      issue_q   <= 1'b0;
      sr_q      <= {RD_LATENCY{1'b0}};
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      od_q      <= {W{1'b0}};
      ov_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dim_q     <= dim_d;
      n_q       <= n_d;
      issued_q  <= issued_d;
      emitted_q <= emitted_d;
      addr_q    <= addr_d;
      issue_q   <= issue_d;
      sr_q      <= sr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      od_q      <= od_d;
      ov_q      <= ov_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x_updated_rd_addr = addr_q;
  assign x_out_data        = od_q;
  assign x_out_valid       = ov_q;
  assign x_out_last        = last_s;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_sgd_x_updated_drain.sv
// Testbench for sgd_x_updated_drain: BRAM model with fixed read latency,
// scoreboard of expected beats filled at start, independent monitor.

`ifndef NUM_BITS_PER_BANK
`define NUM_BITS_PER_BANK 4
`endif
`ifndef DIS_X_BIT_DEPTH
`define DIS_X_BIT_DEPTH 10
`endif
`ifndef BIT_WIDTH_OF_BANK
`define BIT_WIDTH_OF_BANK 2
`endif
`ifndef ENGINE_NUM_WIDTH
`define ENGINE_NUM_WIDTH 1
`endif

module tb_sgd_x_updated_drain;
  localparam int LANES      = `NUM_BITS_PER_BANK;
  localparam int ADDR_BITS  = `DIS_X_BIT_DEPTH;
  localparam int L          = 2;
  localparam int D          = 4;
  localparam int W          = LANES * 32;
  localparam int S          = `BIT_WIDTH_OF_BANK + `ENGINE_NUM_WIDTH;
  localparam int WORD_ELEMS = 1 << S;

  logic                 clk, rst_n, start, x_out_ready;
  logic [31:0]          dimension;
  logic [ADDR_BITS-1:0] x_updated_rd_addr;
  logic [W-1:0]         x_updated_rd_data, x_out_data;
  logic                 x_out_valid, x_out_last, busy, done;

  sgd_x_updated_drain #(.LANES(LANES), .ADDR_BITS(ADDR_BITS), .RD_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dimension(dimension),
    .x_updated_rd_addr(x_updated_rd_addr), .x_updated_rd_data(x_updated_rd_data),
    .x_out_data(x_out_data), .x_out_valid(x_out_valid), .x_out_ready(x_out_ready),
    .x_out_last(x_out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: word at the sampled address appears L cycles later.
  logic [W-1:0] bram [1 << ADDR_BITS];
  logic [W-1:0] rdpipe [L];
  always @(posedge clk) begin
    rdpipe[0] <= bram[x_updated_rd_addr];
    for (int i = 1; i < L; i++) rdpipe[i] <= rdpipe[i-1];
  end
  assign x_updated_rd_data = rdpipe[L-1];

  typedef struct packed { logic [W-1:0] data; logic last; } beat_t;
  beat_t exp_q[$];

  int total = 0, bad = 0;
  int cyc = 0, t0 = 0;
  int mode = 0, phase = 0;
  int beats, first_valid, done_cyc, max_addr, first_beat, last_beat, exp_n;
  logic busy_at1;
  logic prev_hold;
  logic [W-1:0] prev_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pops, hold-stability and outstanding-read bound.
  always @(negedge clk) begin
    int rel;
    beat_t e;
    rel = cyc - t0;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        total++;
        if (!(x_out_valid && x_out_data == prev_data)) begin
          bad++;
          $display("FAIL hold_stable: valid=%0b data=%0h required data=%0h", x_out_valid, x_out_data, prev_data);
        end
      end
      if (x_out_valid && x_out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: data=%0h", x_out_data);
        end else begin
          e = exp_q.pop_front();
          if (x_out_data !== e.data || x_out_last !== e.last) begin
            bad++;
            $display("FAIL beat: data=%0h last=%0b required data=%0h last=%0b", x_out_data, x_out_last, e.data, e.last);
          end
        end
        beats++;
        if (first_beat < 0) first_beat = rel;
        last_beat = rel;
      end
      if (x_out_valid && first_valid < 0) first_valid = rel;
      if (done && done_cyc < 0) done_cyc = rel;
      if (rel == 1) busy_at1 = busy;
      if (busy) begin
        if (int'(x_updated_rd_addr) > max_addr) max_addr = int'(x_updated_rd_addr);
        total++;
        if (max_addr + 1 - beats > D) begin
          bad++;
          $display("FAIL outstanding: got %0d allowed %0d", max_addr + 1 - beats, D);
        end
      end
      prev_hold = x_out_valid && !x_out_ready;
      prev_data = x_out_data;
    end
  end

  task automatic check(string name, logic [W-1:0] got, logic [W-1:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    case (mode)
      0: x_out_ready = 1'b1;
      1: x_out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
      2: x_out_ready = 1'($urandom_range(0, 1));
      default: x_out_ready = 1'b0;
    endcase
    phase++;
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < 64; k++)
      for (int l = 0; l < LANES; l++) bram[k][l*32 +: 32] = 32'(k + 256);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 64; k++)
      for (int l = 0; l < LANES; l++) bram[k][l*32 +: 32] = $urandom;
  endtask

  // Reference: N = ceil(dimension / WORD_ELEMS); words 0..N-1 in order.
  task automatic start_drain(input logic [31:0] dim);
    longint n;
    beat_t b;
    n = (longint'(dim) + WORD_ELEMS - 1) / WORD_ELEMS;
    exp_n = int'(n);
    for (int k = 0; k < exp_n; k++) begin
      b.data = bram[k];
      b.last = (k == exp_n - 1);
      exp_q.push_back(b);
    end
    beats = 0; first_valid = -1; done_cyc = -1; max_addr = -1;
    first_beat = -1; last_beat = -1; busy_at1 = 1'b0; phase = 0;
    start = 1'b1;
    dimension = dim;
    t0 = cyc;
    tick();
    start = 1'b0;
    dimension = $urandom;
  endtask

  task automatic wait_done(string name);
    int n;
    n = 0;
    while (done_cyc < 0 && n < 400) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, W'(done_cyc >= 0), W'(1));
    check({name, "_beats"}, W'(beats), W'(exp_n));
    check({name, "_queue_left"}, W'(exp_q.size()), W'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dimension = 32'd0; x_out_ready = 1'b0;
    beats = 0; first_valid = -1; done_cyc = -1; max_addr = -1;
    first_beat = -1; last_beat = -1; prev_hold = 1'b0; busy_at1 = 1'b0;
    fill_pattern();
    for (int i = 0; i < L; i++) rdpipe[i] = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_addr",  W'(x_updated_rd_addr), W'(0));
    check("rst_data",  x_out_data, W'(0));
    check("rst_valid", W'(x_out_valid), W'(0));
    check("rst_last",  W'(x_out_last), W'(0));
    check("rst_busy",  W'(busy), W'(0));
    check("rst_done",  W'(done), W'(0));
    rst_n = 1'b1;
    mode = 0;
    tick(); tick();

    // Three full words with ready high.
    start_drain(32'(3 * WORD_ELEMS));
    wait_done("three");
    check("three_first_valid", W'(first_valid), W'(5));
    check("three_done_cycle",  W'(done_cyc), W'(8));
    check("three_busy_c1",     W'(busy_at1), W'(1));
    check("three_busy_after",  W'(busy), W'(0));
    check("three_done_pulse",  W'(done), W'(0));
    tick();

    // Partial trailing word.
    start_drain(32'(3 * WORD_ELEMS + 1));
    wait_done("partial");
    tick();

    // Backpressure pattern 1,0,0,1.
    mode = 1;
    start_drain(32'(8 * WORD_ELEMS));
    wait_done("bp");
    mode = 0; tick();

    // Full stall then release.
    mode = 3;
    start_drain(32'(8 * WORD_ELEMS));
    repeat (20) tick();
    check("stall_reads", W'(max_addr + 1), W'(4));
    check("stall_no_beats", W'(beats), W'(0));
    mode = 0;
    wait_done("stall");
    check("stall_contiguous", W'(last_beat - first_beat), W'(7));
    tick();

    // Zero dimension.
    start_drain(32'd0);
    wait_done("zero");
    check("zero_done_cycle", W'(done_cyc), W'(2));
    check("zero_no_valid", W'(first_valid), W'(-1));
    tick();

    // Start pulse during a drain is ignored.
    start_drain(32'(5 * WORD_ELEMS));
    tick(); tick();
    start = 1'b1; dimension = 32'(2 * WORD_ELEMS);
    tick();
    start = 1'b0;
    wait_done("ignored_start");
    tick();

    // Reset in the middle of a drain.
    start_drain(32'(8 * WORD_ELEMS));
    for (int n = 0; n < 200 && beats < 3; n++) tick();
    check("midrst_reached", W'(beats >= 3), W'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_valid", W'(x_out_valid), W'(0));
    check("midrst_data",  x_out_data, W'(0));
    check("midrst_addr",  W'(x_updated_rd_addr), W'(0));
    check("midrst_busy",  W'(busy), W'(0));
    check("midrst_last",  W'(x_out_last), W'(0));
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    start_drain(32'(2 * WORD_ELEMS));
    wait_done("after_rst");
    check("after_rst_max_addr", W'(max_addr), W'(1));
    tick();

    // Randomized drains with random backpressure and data.
    mode = 2;
    for (int t = 0; t < 8; t++) begin
      fill_random();
      start_drain(32'($urandom_range(0, 12 * WORD_ELEMS)));
      wait_done("random");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
